// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// No logic: enum, PC-select encodings and default register-address width.
// No flow control; compile before every file that imports it.
package pipe_ctrl_pkg;

    localparam int REG_W_DFLT = 5;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_STALL = 2'd1,
        IRQ_TAKE  = 2'd2,
        IRQ_HOLD  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_J   = 2'd2;
    localparam logic [1:0] PCSEL_EXC = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
// Purely combinational, zero latency.
// No flow control; the result is consumed by the sequencer and the forwarding unit.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DFLT
)
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: advance/stall/flush/redirect, mem-wait freeze, IRQ entry.
// Control outputs are combinational (0 cycles); irq_ack and mem_timeout are registered (1 cycle).
// mem_wait freezes the whole pipe; PIPE_CTRL_PERF_EN adds stall/freeze/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DFLT,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
)
(
    input  logic             sysclk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             irq_req,
    input  logic             irq_en,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             epc_write,
    output logic             irq_ack,
    output logic             mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      freeze_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic [TMO_W-1:0] wait_cnt_nxt;
    logic             tmo_set;
    logic             lu_stall;
    logic             load_use;
    logic             irq_go;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    // IRQ_HOLD masks the interrupt path until the request line drops.
    assign irq_go = irq_req && irq_en && (state == RUN);

    // Per-cycle sequencing decision; reset forces the flush-everything pattern.
    always_comb begin
        pc_write     = 1'b1;
        pc_sel       = PCSEL_SEQ;
        if_id_write  = 1'b1;
        if_flush     = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        epc_write    = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        tmo_set      = 1'b0;
        lu_stall     = 1'b0;
        case (state)
            RUN, IRQ_HOLD: begin
                if (state == IRQ_HOLD && !irq_req) begin
                    state_nxt = RUN;
                end
                if (mem_wait) begin
                    pipe_freeze  = 1'b1;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    state_nxt    = MEM_STALL;
                    wait_cnt_nxt = TMO_W'(1);
                end else if (ex_branch_taken) begin
                    // A coincident IRQ is taken next cycle so EPC holds the branch target.
                    pc_sel      = PCSEL_BR;
                    if_flush    = 1'b1;
                    id_ex_flush = 1'b1;
                    if (irq_go) begin
                        state_nxt = IRQ_TAKE;
                    end
                end else if (irq_go) begin
                    state_nxt = IRQ_TAKE;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    lu_stall    = 1'b1;
                end else if (id_jump) begin
                    pc_sel   = PCSEL_J;
                    if_flush = 1'b1;
                end
            end
            MEM_STALL: begin
                // Release cycle advances unconditionally; hazards are looked at next cycle.
                if (mem_wait) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (wait_cnt >= TMO_MAX) begin
                        tmo_set      = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + TMO_W'(1);
                    end
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            IRQ_TAKE: begin
                pc_sel      = PCSEL_EXC;
                if_flush    = 1'b1;
                id_ex_flush = 1'b1;
                epc_write   = 1'b1;
                state_nxt   = IRQ_HOLD;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (!reset) begin
            pc_write    = 1'b0;
            pc_sel      = PCSEL_SEQ;
            if_id_write = 1'b0;
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
            pipe_freeze = 1'b0;
            epc_write   = 1'b0;
            lu_stall    = 1'b0;
        end
    end

    // FSM state, wait counter and the two registered status outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            irq_ack     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            irq_ack  <= (state == IRQ_TAKE);
            if (tmo_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lu_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (state == MEM_STALL) begin
                freeze_cnt <= freeze_cnt + 32'd1;
            end
            if (if_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
